// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_pkg
// Brief    : Shared types and constants for the execute-stage ALU datapath.
//            ALU operation encoding, default datapath width and the values
//            the EX/MEM result registers take on reset or flush.
// Revision : 1.0 - initial release
// ============================================================================
package ex_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int OPW_DEF   = 3;

    typedef enum logic [OPW_DEF-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    // Registered outputs after reset/flush: result cleared, zero flag set
    // (a cleared result is, consistently, zero).
    localparam logic RST_RESULT_BIT = 1'b0;
    localparam logic RST_ZERO       = 1'b1;
    localparam logic RST_EXT_FLAG   = 1'b0;

endpackage : ex_pkg
`default_nettype wire

// File: rtl/ex_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : ex_alu_core
// Brief    : Purely combinational ALU: 8-op decode and zero flag.
//            Optional macro ALU_EXT_FLAGS_EN adds negative/carry/overflow.
// Revision : 1.0 - initial release
// ============================================================================
module ex_alu_core
    import ex_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [OPW-1:0]   i_alu_op,
    output logic [WIDTH-1:0] o_result,
`ifdef ALU_EXT_FLAGS_EN
    output logic             o_negative,
    output logic             o_carry,
    output logic             o_overflow,
`endif
    output logic             o_zero
);

    localparam int SHW = $clog2(WIDTH);

    // Only the low log2(WIDTH) bits of b form the shift amount.
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_slt;

    assign w_shamt = i_b[SHW-1:0];
    assign w_slt   = ($signed(i_a) < $signed(i_b));

`ifdef ALU_EXT_FLAGS_EN
    // One extra bit captures carry-out of ADD and no-borrow of SUB.
    logic [WIDTH:0] w_add_c;
    logic [WIDTH:0] w_sub_c;

    assign w_add_c = {1'b0, i_a} + {1'b0, i_b};
    assign w_sub_c = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_sum   = w_add_c[WIDTH-1:0];
    assign w_diff  = w_sub_c[WIDTH-1:0];
`else
    assign w_sum   = i_a + i_b;
    assign w_diff  = i_a - i_b;
`endif

    // Operation select; every code is defined so no X leaks out.
    always_comb begin
        o_result = '0;
        case (i_alu_op)
            ALU_ADD: o_result = w_sum;
            ALU_SUB: o_result = w_diff;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            ALU_SLL: o_result = i_a << w_shamt;
            ALU_SRL: o_result = i_a >> w_shamt;
            ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, w_slt};
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

`ifdef ALU_EXT_FLAGS_EN
    // Carry/overflow only meaningful for ADD and SUB; forced low otherwise.
    always_comb begin
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        case (i_alu_op)
            ALU_ADD: begin
                o_carry    = w_add_c[WIDTH];
                o_overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            ALU_SUB: begin
                o_carry    = w_sub_c[WIDTH];
                o_overflow = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            default: begin
                o_carry    = 1'b0;
                o_overflow = 1'b0;
            end
        endcase
    end

    assign o_negative = o_result[WIDTH-1];
`endif

endmodule : ex_alu_core
`default_nettype wire

// File: rtl/ex_alu_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_alu_stage
// Brief    : Execute stage: ALU, zero flag, branch-target adder and an
//            EX/MEM-facing result register with stall (en) and flush.
//            Optional macro ALU_EXT_FLAGS_EN adds negative/carry/overflow
//            flags and their registered copies.
// Revision : 1.0 - initial release
// ============================================================================
module ex_alu_stage
    import ex_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] branch_target,
`ifdef ALU_EXT_FLAGS_EN
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             negative_q,
    output logic             carry_q,
    output logic             overflow_q,
`endif
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q
);

    logic [WIDTH-1:0] w_result;
    logic             w_zero;
    logic [WIDTH-1:0] w_imm_sh;
    logic [WIDTH-1:0] r_result_q;
    logic             r_zero_q;

`ifdef ALU_EXT_FLAGS_EN
    logic w_negative;
    logic w_carry;
    logic w_overflow;
    logic r_negative_q;
    logic r_carry_q;
    logic r_overflow_q;
`endif

    ex_alu_core #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_core (
        .i_a        (a),
        .i_b        (b),
        .i_alu_op   (alu_op),
        .o_result   (w_result),
`ifdef ALU_EXT_FLAGS_EN
        .o_negative (w_negative),
        .o_carry    (w_carry),
        .o_overflow (w_overflow),
`endif
        .o_zero     (w_zero)
    );

    // Branch offsets are halfword-scaled; the MSB of imm falls off the top.
    assign w_imm_sh      = imm << 1;
    assign branch_target = pc + w_imm_sh;

    assign result = w_result;
    assign zero   = w_zero;

    // Result register: reset > flush > en load > hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result_q <= {WIDTH{RST_RESULT_BIT}};
            r_zero_q   <= RST_ZERO;
        end else if (flush) begin
            r_result_q <= {WIDTH{RST_RESULT_BIT}};
            r_zero_q   <= RST_ZERO;
        end else if (en) begin
            r_result_q <= w_result;
            r_zero_q   <= w_zero;
        end
    end

    assign result_q = r_result_q;
    assign zero_q   = r_zero_q;

`ifdef ALU_EXT_FLAGS_EN
    assign negative = w_negative;
    assign carry    = w_carry;
    assign overflow = w_overflow;

    // Extended flag registers follow the same priority as the result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_negative_q <= RST_EXT_FLAG;
            r_carry_q    <= RST_EXT_FLAG;
            r_overflow_q <= RST_EXT_FLAG;
        end else if (flush) begin
            r_negative_q <= RST_EXT_FLAG;
            r_carry_q    <= RST_EXT_FLAG;
            r_overflow_q <= RST_EXT_FLAG;
        end else if (en) begin
            r_negative_q <= w_negative;
            r_carry_q    <= w_carry;
            r_overflow_q <= w_overflow;
        end
    end

    assign negative_q = r_negative_q;
    assign carry_q    = r_carry_q;
    assign overflow_q = r_overflow_q;
`endif

endmodule : ex_alu_stage
`default_nettype wire

// File: tb/tb_ex_alu_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_alu_stage
// Brief    : Self-checking bench for ex_alu_stage. Combinational outputs are
//            compared against a reference model right after each stimulus;
//            expected registered outputs are queued and popped by a monitor
//            after every rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_alu_stage;

    localparam int W = 64;
    localparam logic [W-1:0] C_MAX = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] C_MIN = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] C_POS = 64'h7FFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         flush;
    logic [W-1:0] a, b, pc, imm;
    logic [2:0]   alu_op;
    logic [W-1:0] result, branch_target, result_q;
    logic         zero, zero_q;
`ifdef ALU_EXT_FLAGS_EN
    logic         negative, carry, overflow, negative_q, carry_q, overflow_q;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] mdl_q;
    logic         mdl_zq;
    bit           mon_en = 1'b0;

    ex_alu_stage u_dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .flush         (flush),
        .a             (a),
        .b             (b),
        .alu_op        (alu_op),
        .pc            (pc),
        .imm           (imm),
        .result        (result),
        .zero          (zero),
        .branch_target (branch_target),
`ifdef ALU_EXT_FLAGS_EN
        .negative      (negative),
        .carry         (carry),
        .overflow      (overflow),
        .negative_q    (negative_q),
        .carry_q       (carry_q),
        .overflow_q    (overflow_q),
`endif
        .result_q      (result_q),
        .zero_q        (zero_q)
    );

    always #5 clk = ~clk;

    // Reference ALU written straight from the operation table.
    function automatic logic [W-1:0] ref_alu(input logic [2:0] op,
                                             input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        int sh;
        sh = int'(y % 64);
        case (op)
            3'd0: return x + y;
            3'd1: return x - y;
            3'd2: return x & y;
            3'd3: return x | y;
            3'd4: return x ^ y;
            3'd5: return x << sh;
            3'd6: return x >> sh;
            default: return ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, check combinational outputs, and queue
    // the registered value expected after the coming rising edge.
    task automatic step(input logic e, input logic f, input logic [2:0] op,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] p, input logic [W-1:0] i);
        logic [W-1:0] exp;
        @(negedge clk);
        en = e; flush = f; alu_op = op; a = x; b = y; pc = p; imm = i;
        #1;
        exp = ref_alu(op, x, y);
        chk("result", result, exp);
        chk("zero", {63'd0, zero}, {63'd0, (exp == 0)});
        chk("branch_target", branch_target, p + i * 2);
`ifdef ALU_EXT_FLAGS_EN
        begin
            logic [W:0] s;
            logic       cy, ov;
            cy = 1'b0; ov = 1'b0;
            if (op == 3'd0) begin
                s  = {1'b0, x} + {1'b0, y};
                cy = s[W];
                s  = {x[W-1], x} + {y[W-1], y};
                ov = s[W] != s[W-1];
            end else if (op == 3'd1) begin
                cy = (x >= y);
                s  = {x[W-1], x} - {y[W-1], y};
                ov = s[W] != s[W-1];
            end
            chk("negative", {63'd0, negative}, {63'd0, exp[W-1]});
            chk("carry", {63'd0, carry}, {63'd0, cy});
            chk("overflow", {63'd0, overflow}, {63'd0, ov});
        end
`endif
        if (f) begin
            mdl_q = '0; mdl_zq = 1'b1;
        end else if (e) begin
            mdl_q = exp; mdl_zq = (exp == 0);
        end
        sb.push_back('{mdl_q, mdl_zq});
        mon_en = 1'b1;
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return C_MAX;
            2: return C_MIN;
            3: return W'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: one expected registered value per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && !rst) begin
                if (sb.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL sb_empty: got no entry expected one");
                end else begin
                    e = sb.pop_front();
                    chk("result_q", result_q, e.r);
                    chk("zero_q", {63'd0, zero_q}, {63'd0, e.z});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0;
        a = 64'h1234; b = 64'h1; alu_op = 3'd0; pc = '0; imm = '0;
        mdl_q = '0; mdl_zq = 1'b1;

        // Reset held through edges with en high
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result_q", result_q, '0);
        chk("rst_zero_q", {63'd0, zero_q}, 64'd1);
        @(negedge clk);
        en = 1'b0;
        rst = 1'b0;

        // First load after reset release, then asynchronous mid-cycle reset
        step(1, 0, 3'd0, 64'h50, 64'h5, 64'h0, 64'h0);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        chk("load_before_rst", result_q, 64'h55);
        rst = 1'b1;
        #1;
        chk("async_rst_result_q", result_q, '0);
        chk("async_rst_zero_q", {63'd0, zero_q}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_result_q", result_q, '0);
        chk("rst_hold_zero_q", {63'd0, zero_q}, 64'd1);
        @(negedge clk);
        en = 1'b0;
        rst = 1'b0;
        mdl_q = '0; mdl_zq = 1'b1;

        // Directed: arithmetic wrap
        step(1, 0, 3'd0, C_MAX, 64'd1, 64'h0, 64'h0);
        chk("add_wrap", result, '0);
        chk("add_wrap_zero", {63'd0, zero}, 64'd1);
        step(1, 0, 3'd1, 64'd5, 64'd7, 64'h0, 64'h0);
        chk("sub_wrap", result, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("add_wrap_q", result_q, '0);

        // Directed: logic and shifts
        step(1, 0, 3'd2, 64'hF0, 64'h3C, 64'h0, 64'h0);
        chk("and", result, 64'h30);
        chk("sub_wrap_q", result_q, 64'hFFFF_FFFF_FFFF_FFFE);
        step(1, 0, 3'd3, 64'hF0, 64'h3C, 64'h0, 64'h0);
        chk("or", result, 64'hFC);
        step(1, 0, 3'd4, 64'hF0, 64'h3C, 64'h0, 64'h0);
        chk("xor", result, 64'hCC);
        step(1, 0, 3'd5, 64'd1, 64'h43, 64'h0, 64'h0);
        chk("sll_amount_mask", result, 64'h8);
        step(1, 0, 3'd5, 64'd3, 64'd64, 64'h0, 64'h0);
        chk("sll_by_64", result, 64'd3);
        step(1, 0, 3'd6, C_MIN, 64'd63, 64'h0, 64'h0);
        chk("srl", result, 64'd1);

        // Directed: signed compare boundaries
        step(1, 0, 3'd7, C_MIN, 64'd0, 64'h0, 64'h0);
        chk("slt_min", result, 64'd1);
        step(1, 0, 3'd7, C_POS, C_MIN, 64'h0, 64'h0);
        chk("slt_max_vs_min", result, 64'd0);
        step(1, 0, 3'd7, 64'd3, 64'd3, 64'h0, 64'h0);
        chk("slt_equal_zero", {63'd0, zero}, 64'd1);

        // Directed: branch adder
        step(1, 0, 3'd0, 64'd0, 64'd0, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("bt_neg", branch_target, 64'hF0);
        step(1, 0, 3'd7, 64'd0, 64'd0, 64'h1000, 64'h10);
        chk("bt_pos", branch_target, 64'h1020);

        // Directed: stall then flush
        step(1, 0, 3'd0, 64'h50, 64'h5, 64'h0, 64'h0);
        step(0, 0, 3'd4, 64'h1234, 64'h1, 64'h0, 64'h0);
        chk("stall_load", result_q, 64'h55);
        step(1, 1, 3'd0, 64'h7, 64'h8, 64'h0, 64'h0);
        chk("stall_hold", result_q, 64'h55);
        step(1, 0, 3'd0, 64'h2, 64'h2, 64'h0, 64'h0);
        chk("flush_result_q", result_q, '0);
        chk("flush_zero_q", {63'd0, zero_q}, 64'd1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                 3'($urandom_range(0, 7)), rnd_val(), rnd_val(),
                 rnd_val(), rnd_val());
        end

        @(posedge clk);
        #3;
        mon_en = 1'b0;
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ex_alu_stage
`default_nettype wire

// File: doc/ex_alu_stage.md
Name: ex_alu_stage

Overview:
- 64-bit integer execute-stage datapath for the pipelined RISC core: ALU, zero flag and branch-target adder.
- Takes operands from the forwarding/ALU-source muxes and the decoded 3-bit ALU control.
- Drives the ALU result combinationally and through an EX/MEM-facing result register with stall and flush control.
- The branch target (pc + imm<<1) is computed in the same stage for the branch decision (zero & branch).

Parameters:
- WIDTH, 64, datapath width in bits; must be a power of two ≥ 8.
- OPW, 3, ALU control width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- en  in  1  register load enable; 0 = stall/hold
- flush  in  1  synchronous clear of registered outputs
- a  in  WIDTH  operand A (rs1 path)
- b  in  WIDTH  operand B (rs2 or immediate, already muxed)
- alu_op  in  OPW  operation select
- pc  in  WIDTH  PC of the instruction in EX
- imm  in  WIDTH  sign-extended immediate
- result  out  WIDTH  combinational ALU result
- zero  out  1  combinational; 1 when result == 0
- branch_target  out  WIDTH  combinational pc + (imm << 1)
- result_q  out  WIDTH  registered result
- zero_q  out  1  registered zero flag

Behaviour:
- alu_op encoding:
  - 000 ADD: a+b
  - 001 SUB: a−b
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLL: a << b[log2(WIDTH)-1:0]
  - 110 SRL: logical right shift, same amount field
  - 111 SLT: signed a<b → 1, else 0, zero-extended
- All arithmetic is modulo 2^WIDTH; carries are discarded and no trap is raised.
- Shift amount uses only the low log2(WIDTH) bits of b; upper bits are ignored (b=64 → shift by 0).
- SLT at the boundaries: a=0x8000…0, b=0 → 1; a=0x7FFF…F, b=0x8000…0 → 0.
- zero is purely combinational from result, including for SLT.
- branch_target: imm shifted left 1 (MSB dropped), added to pc, wrap-around modulo 2^WIDTH. Independent of alu_op.
- Register update order, each edge:
  - rst asserted (any time, asynchronous): result_q=0, zero_q=1. Reset dominates all other inputs.
  - else flush=1 at rising clk: result_q=0, zero_q=1. flush has priority over en.
  - else en=1: result_q←result, zero_q←zero.
  - else hold.
- Latency:
  - Combinational outputs settle within the same cycle.
  - Registered outputs reflect inputs sampled at the previous rising edge (1-cycle latency).
- Releasing reset mid-operation: first load occurs at the first rising edge with rst low and en high.
- No X propagation from unused alu_op codes: all 8 codes are defined.

Optional Feature:
- Macro ALU_EXT_FLAGS_EN.
- When defined, adds outputs negative (result MSB), carry (carry-out of ADD / no-borrow of SUB, 0 for other ops) and overflow (signed overflow of ADD/SUB, 0 otherwise).
- Each new flag is combinational and has a registered _q copy following the same reset/flush/en rules, with reset/flush value 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package ex_pkg:
  - alu_op_e enum (ALU_ADD…ALU_SLT, OPW bits)
  - WIDTH default constant
  - reset constants for result_q/zero_q
- One natural sub-module: ex_alu_core, a purely combinational op decode plus zero flag (plus ext flags). The top adds the branch adder and output registers.

Test Plan:
- Reset: rst=1 asynchronously mid-cycle with en=1 → result_q=0, zero_q=1 immediately; hold rst through 2 edges, values unchanged.
- ADD/SUB wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=1, op=000 → result=0, zero=1; op=001, a=5, b=7 → result=0xFFFF_FFFF_FFFF_FFFE, zero=0; result_q matches one edge later.
- Logic/shift: a=0xF0, b=0x3C → AND 0x30, OR 0xFC, XOR 0xCC; a=1, b=0x43, op=101 → 0x8; a=0x8000_0000_0000_0000, b=63, op=110 → 1.
- SLT signed: a=0x8000_0000_0000_0000, b=0 → 1; a=3, b=3 → 0 with zero=1.
- Branch adder: pc=0x100, imm=0xFFFF_FFFF_FFFF_FFF8 (−8) → branch_target=0xF0; pc=0x1000, imm=0x10 → 0x1020.
- Stall/flush: load result 0x55 with en=1; en=0 with new inputs → result_q stays 0x55; flush=1 with en=1 → result_q=0, zero_q=1.
